// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// the down-counter load-value helper.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } state_e;

  // Load value for a down-counter that must run for 'cycles' cycles; caller truncates to CNT_W.
  function automatic logic [31:0] cnt_load(input logic [31:0] cycles);
    return cycles - 32'd1;
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger/level bundle between a pulse stretcher and its driver/observer.
interface pulse_stretcher_if #(
  parameter int DROP_W = 8
) ();

  logic              signal_in;
  logic              clear_drops;
  logic              signal_out;
  logic              busy;
  logic              dropped;
  logic [DROP_W-1:0] drop_count;

  modport master (
    output signal_in,
    output clear_drops,
    input  signal_out,
    input  busy,
    input  dropped,
    input  drop_count
  );

  modport slave (
    input  signal_in,
    input  clear_drops,
    output signal_out,
    output busy,
    output dropped,
    output drop_count
  );

endinterface

// File: rtl/pulse_stretcher_sat_counter.sv
// Generic saturating status counter: increments on inc, sticks at all-ones,
// clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] count_r;

  // Count register with clear-over-increment priority and saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into a fixed-length high level, with an
// optional forced-low guard gap and retrigger-or-drop handling while busy.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int HOLD_CYCLES = 5000000,
  parameter int GAP_CYCLES  = 0,
  parameter int RETRIGGER   = 0,
  parameter int DROP_W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  pulse_stretcher_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(cnt_load(32'(HOLD_CYCLES)));
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(cnt_load(32'(GAP_CYCLES)));
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               HAS_GAP   = (GAP_CYCLES > 0);
  localparam bit               RETRIG_EN = (RETRIGGER != 0);

  state_e             state_r;
  state_e             state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;

  logic               signal_out_s;
  logic               busy_s;
  logic               drop_s;
  logic               signal_out_r;
  logic               busy_r;
  logic               dropped_r;
  logic [DROP_W-1:0]  drop_count_s;

  // State and hold/gap counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state and counter update; the unused 2'b11 encoding falls back to IDLE.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.signal_in) begin
          state_next_s = HOLD;
          cnt_next_s   = HOLD_LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      HOLD: begin
        if (RETRIG_EN && bus.signal_in) begin
          cnt_next_s = HOLD_LOAD;
        end else if (cnt_r != CNT_ZERO) begin
          cnt_next_s = cnt_r - CNT_ONE;
        end else if (HAS_GAP) begin
          state_next_s = GAP;
          cnt_next_s   = GAP_LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      GAP: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_next_s = cnt_r - CNT_ONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode: levels follow the next state so they appear registered with it;
  // a drop is any trigger seen while busy that does not retrigger the hold.
  always_comb begin
    signal_out_s = (state_next_s == HOLD);
    busy_s       = (state_next_s != IDLE);
    drop_s       = 1'b0;
    case (state_r)
      HOLD:    drop_s = bus.signal_in & ~RETRIG_EN;
      GAP:     drop_s = bus.signal_in;
      default: drop_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      signal_out_r <= 1'b0;
      busy_r       <= 1'b0;
      dropped_r    <= 1'b0;
    end else begin
      signal_out_r <= signal_out_s;
      busy_r       <= busy_s;
      dropped_r    <= drop_s;
    end
  end

  sat_counter #(
    .W (DROP_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_s),
    .clr   (bus.clear_drops),
    .count (drop_count_s)
  );

  assign bus.signal_out = signal_out_r;
  assign bus.busy       = busy_r;
  assign bus.dropped    = dropped_r;
  assign bus.drop_count = drop_count_s;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: five instances cover the parameter
// corners; directed per-cycle vectors push expectations, a monitor checks them.
module tb_pulse_stretcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0] sin_v = '0;
  logic [4:0] clr_v = '0;
  logic [4:0] so_v;
  logic [4:0] bs_v;
  logic [4:0] dp_v;
  logic [7:0] cnt_v [5];

  pulse_stretcher_if #(.DROP_W(8)) if0 ();
  pulse_stretcher_if #(.DROP_W(8)) if1 ();
  pulse_stretcher_if #(.DROP_W(8)) if2 ();
  pulse_stretcher_if #(.DROP_W(2)) if3 ();
  pulse_stretcher_if #(.DROP_W(8)) if4 ();

  // inst0: no retrigger, gap 2
  pulse_stretcher #(.CNT_W(24), .HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(0), .DROP_W(8))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  // inst1: retrigger, gap 2
  pulse_stretcher #(.CNT_W(24), .HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1), .DROP_W(8))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  // inst2: no retrigger, no gap
  pulse_stretcher #(.CNT_W(24), .HOLD_CYCLES(4), .GAP_CYCLES(0), .RETRIGGER(0), .DROP_W(8))
    dut2 (.clk(clk), .rst(rst), .bus(if2));
  // inst3: narrow drop counter for saturation
  pulse_stretcher #(.CNT_W(8), .HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(0), .DROP_W(2))
    dut3 (.clk(clk), .rst(rst), .bus(if3));
  // inst4: single-cycle hold
  pulse_stretcher #(.CNT_W(4), .HOLD_CYCLES(1), .GAP_CYCLES(0), .RETRIGGER(0), .DROP_W(8))
    dut4 (.clk(clk), .rst(rst), .bus(if4));

  assign if0.signal_in = sin_v[0];  assign if0.clear_drops = clr_v[0];
  assign if1.signal_in = sin_v[1];  assign if1.clear_drops = clr_v[1];
  assign if2.signal_in = sin_v[2];  assign if2.clear_drops = clr_v[2];
  assign if3.signal_in = sin_v[3];  assign if3.clear_drops = clr_v[3];
  assign if4.signal_in = sin_v[4];  assign if4.clear_drops = clr_v[4];

  assign so_v = {if4.signal_out, if3.signal_out, if2.signal_out, if1.signal_out, if0.signal_out};
  assign bs_v = {if4.busy, if3.busy, if2.busy, if1.busy, if0.busy};
  assign dp_v = {if4.dropped, if3.dropped, if2.dropped, if1.dropped, if0.dropped};
  assign cnt_v[0] = if0.drop_count;
  assign cnt_v[1] = if1.drop_count;
  assign cnt_v[2] = if2.drop_count;
  assign cnt_v[3] = {6'b0, if3.drop_count};
  assign cnt_v[4] = if4.drop_count;

  typedef struct {
    int         cyc;
    int         idx;
    int         step;
    logic       so;
    logic       bs;
    logic       dp;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt [5] = '{0, 0, 0, 0, 0};
  int   cnt_max [5] = '{255, 255, 255, 3, 255};

  function automatic bit ch(input string s, input int k);
    if (k < s.len()) return (s.getc(k) == 8'h31);
    else return 1'b0;
  endfunction

  // One character per cycle: input sampled at the next edge, outputs expected right after it.
  task automatic run(input int idx, input string name, input string in_s, input string clr_s,
                     input string rst_s, input string so_s, input string bs_s, input string dp_s);
    for (int k = 0; k < in_s.len(); k++) begin
      exp_t e;
      sin_v      = '0;
      clr_v      = '0;
      sin_v[idx] = ch(in_s, k);
      clr_v[idx] = ch(clr_s, k);
      rst        = ch(rst_s, k);
      if (ch(rst_s, k)) begin
        for (int j = 0; j < 5; j++) exp_cnt[j] = 0;
      end else if (ch(clr_s, k)) begin
        exp_cnt[idx] = 0;
      end else if (ch(dp_s, k) && exp_cnt[idx] < cnt_max[idx]) begin
        exp_cnt[idx] = exp_cnt[idx] + 1;
      end
      e.cyc  = cyc + 1;
      e.idx  = idx;
      e.step = k;
      e.so   = ch(so_s, k);
      e.bs   = ch(bs_s, k);
      e.dp   = ch(dp_s, k);
      e.cnt  = 8'(exp_cnt[idx]);
      e.name = name;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
    end
    sin_v = '0;
    clr_v = '0;
    rst   = 1'b0;
  endtask

  // Monitor: compare every expectation that has come due.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_tests++;
      if (e.cyc != cyc || so_v[e.idx] !== e.so || bs_v[e.idx] !== e.bs ||
          dp_v[e.idx] !== e.dp || cnt_v[e.idx] !== e.cnt) begin
        n_fail++;
        $display("FAIL %s[%0d] inst%0d cyc%0d: got so=%b busy=%b dropped=%b cnt=%0d, want so=%b busy=%b dropped=%b cnt=%0d",
                 e.name, e.step, e.idx, cyc, so_v[e.idx], bs_v[e.idx], dp_v[e.idx], cnt_v[e.idx],
                 e.so, e.bs, e.dp, e.cnt);
      end
    end
  end

  initial begin
    for (int i = 0; i < 5; i++) run(i, "reset", "0", "", "1", "0", "0", "0");

    run(0, "iso_gap_drop", "100001000", "", "",
        "111100000", "111111000", "000001000");
    run(0, "hold_edges", "0101010110000000", "", "",
        "0111100011110000", "0111111011111100", "0001010100000000");
    run(0, "rst_mid_hold", "1010010000000", "", "0010000000000",
        "1100011110000", "1100011111100", "0000000000000");

    run(1, "retrig", "1010000100000", "", "",
        "1111110000000", "1111111100000", "0000000100000");
    run(1, "retrig_held", "11111000000000", "", "",
        "11111111000000", "11111111110000", "00000000000000");
    run(1, "retrig_last", "1000100000000", "", "",
        "1111111100000", "1111111111000", "0000000000000");

    run(2, "held_nogap", "1111111111111111111100", "", "",
        "1111011110111101111000", "1111011110111101111000", "0111101111011110111100");

    run(3, "sat_clear", "11111111101000000000", "00000000100000000010", "",
        "11110001111000000000", "11111101111110000000", "01111110101000000000");

    run(4, "hold1_alt", "10101010100", "", "",
        "10101010100", "10101010100", "00000000000");
    run(4, "hold1_b2b", "1100", "", "",
        "1000", "1000", "0100");

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
